// File: rtl/bus_demux_1to2_if.sv
// Bus bundle for the 1-to-2 request router: upstream core request/response
// plus the shared downstream request fields and the per-port A/B handshakes.
interface bus_demux_1to2_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] dn_addr;
    logic        dn_we;
    logic [31:0] dn_wdata;
    logic [3:0]  dn_wstrb;

    logic        a_valid;
    logic        a_ready;
    logic        a_resp_valid;
    logic [31:0] a_rdata;

    logic        b_valid;
    logic        b_ready;
    logic        b_resp_valid;
    logic [31:0] b_rdata;

    // Router side
    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, req_wstrb,
        input  a_ready, a_resp_valid, a_rdata,
        input  b_ready, b_resp_valid, b_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output dn_addr, dn_we, dn_wdata, dn_wstrb, a_valid, b_valid
    );

    // Environment side: core plus both downstream targets
    modport master (
        output req_valid, req_addr, req_we, req_wdata, req_wstrb,
        output a_ready, a_resp_valid, a_rdata,
        output b_ready, b_resp_valid, b_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  dn_addr, dn_we, dn_wdata, dn_wstrb, a_valid, b_valid
    );
endinterface

// File: rtl/bus_demux_1to2.sv
// Single-outstanding 1-to-2 request router: decodes the request address, steers
// it to port A (default) or port B (window), and returns one response or a timeout error.
module bus_demux_1to2 #(
    parameter logic [31:0] B_BASE   = 32'h1000_0000,
    parameter logic [31:0] B_MASK   = 32'hF000_0000,
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input logic             clk,
    input logic             rst_n,
    bus_demux_1to2_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state, state_nxt;
    logic               sel_b, sel_b_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               a_vld_q, a_vld_nxt;
    logic               b_vld_q, b_vld_nxt;
    logic               resp_vld_q, resp_vld_nxt;
    logic               resp_err_q, resp_err_nxt;
    logic [31:0]        resp_rdata_q, resp_rdata_nxt;
    logic [31:0]        dn_addr_q, dn_addr_nxt;
    logic               dn_we_q, dn_we_nxt;
    logic [31:0]        dn_wdata_q, dn_wdata_nxt;
    logic [3:0]         dn_wstrb_q, dn_wstrb_nxt;

    logic               addr_is_b;
    logic               sel_ready;
    logic               sel_resp;
    logic [31:0]        sel_rdata;
    logic               timed_out;

    assign addr_is_b = (bus.req_addr & B_MASK) == B_BASE;
    assign sel_ready = sel_b ? bus.b_ready      : bus.a_ready;
    assign sel_resp  = sel_b ? bus.b_resp_valid : bus.a_resp_valid;
    assign sel_rdata = sel_b ? bus.b_rdata      : bus.a_rdata;
    assign timed_out = cnt == CNT_W'(TIMEOUT - 1);

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            sel_b        <= 1'b0;
            cnt          <= '0;
            a_vld_q      <= 1'b0;
            b_vld_q      <= 1'b0;
            resp_vld_q   <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            dn_addr_q    <= '0;
            dn_we_q      <= 1'b0;
            dn_wdata_q   <= '0;
            dn_wstrb_q   <= '0;
        end else begin
            state        <= state_nxt;
            sel_b        <= sel_b_nxt;
            cnt          <= cnt_nxt;
            a_vld_q      <= a_vld_nxt;
            b_vld_q      <= b_vld_nxt;
            resp_vld_q   <= resp_vld_nxt;
            resp_err_q   <= resp_err_nxt;
            resp_rdata_q <= resp_rdata_nxt;
            dn_addr_q    <= dn_addr_nxt;
            dn_we_q      <= dn_we_nxt;
            dn_wdata_q   <= dn_wdata_nxt;
            dn_wstrb_q   <= dn_wstrb_nxt;
        end
    end

    // Next state; a completion takes priority over a timeout in the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.req_valid) state_nxt = ISSUE;
            ISSUE: begin
                if (sel_ready && sel_resp) state_nxt = DONE;
                else if (timed_out)        state_nxt = DONE;
                else if (sel_ready)        state_nxt = WAIT;
            end
            WAIT:  if (sel_resp || timed_out) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        sel_b_nxt      = sel_b;
        cnt_nxt        = cnt;
        a_vld_nxt      = a_vld_q;
        b_vld_nxt      = b_vld_q;
        resp_vld_nxt   = 1'b0;
        resp_err_nxt   = resp_err_q;
        resp_rdata_nxt = resp_rdata_q;
        dn_addr_nxt    = dn_addr_q;
        dn_we_nxt      = dn_we_q;
        dn_wdata_nxt   = dn_wdata_q;
        dn_wstrb_nxt   = dn_wstrb_q;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    dn_addr_nxt  = bus.req_addr;
                    dn_we_nxt    = bus.req_we;
                    dn_wdata_nxt = bus.req_wdata;
                    dn_wstrb_nxt = bus.req_wstrb;
                    sel_b_nxt    = addr_is_b;
                    a_vld_nxt    = !addr_is_b;
                    b_vld_nxt    = addr_is_b;
                    cnt_nxt      = '0;
                end
            end
            ISSUE, WAIT: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (state == ISSUE && sel_ready) begin
                    a_vld_nxt = 1'b0;
                    b_vld_nxt = 1'b0;
                end
                if (sel_resp && (state == WAIT || sel_ready)) begin
                    resp_vld_nxt   = 1'b1;
                    resp_err_nxt   = 1'b0;
                    resp_rdata_nxt = sel_rdata;
                end else if (timed_out) begin
                    a_vld_nxt      = 1'b0;
                    b_vld_nxt      = 1'b0;
                    resp_vld_nxt   = 1'b1;
                    resp_err_nxt   = 1'b1;
                    resp_rdata_nxt = ERR_DATA;
                end
            end
            default: ;
        endcase
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = resp_vld_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.dn_addr    = dn_addr_q;
    assign bus.dn_we      = dn_we_q;
    assign bus.dn_wdata   = dn_wdata_q;
    assign bus.dn_wstrb   = dn_wstrb_q;
    assign bus.a_valid    = a_vld_q;
    assign bus.b_valid    = b_vld_q;
endmodule

// File: tb/tb_bus_demux_1to2.sv
// Self-checking bench for bus_demux_1to2: expected responses are queued when a
// request is driven and compared when resp_valid pulses.
module tb_bus_demux_1to2;
    logic clk;
    logic rst_n;

    bus_demux_1to2_if bus ();

    bus_demux_1to2 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   a_cyc   = 0;
    int   b_cyc   = 0;
    int   resp_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.a_valid)    a_cyc    <= a_cyc + 1;
        if (bus.b_valid)    b_cyc    <= b_cyc + 1;
        if (bus.resp_valid) resp_cnt <= resp_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] rdata, input logic err);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    task automatic check_resp(input string tag);
        exp_t e;
        check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_underflow"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_rdata"}, bus.resp_rdata, e.rdata);
            check({tag, "_err"}, 32'(bus.resp_err), 32'(e.err));
        end
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic we,
                             input logic [31:0] wdata, input logic [3:0] wstrb);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_we    = we;
        bus.req_wdata = wdata;
        bus.req_wstrb = wstrb;
    endtask

    initial begin
        int a0, b0, r0, hi;
        bus.req_valid = 0; bus.req_addr = 0; bus.req_we = 0; bus.req_wdata = 0; bus.req_wstrb = 0;
        bus.a_ready = 0; bus.a_resp_valid = 0; bus.a_rdata = 0;
        bus.b_ready = 0; bus.b_resp_valid = 0; bus.b_rdata = 0;
        rst_n = 1'b0;
        step(); step();
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_a_valid", 32'(bus.a_valid), 32'd0);
        check("rst_b_valid", 32'(bus.b_valid), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_dn_addr", bus.dn_addr, 32'd0);
        rst_n = 1'b1;
        step();

        // Read from A with a delayed response
        a0 = a_cyc; b0 = b_cyc;
        drive_req(32'h0000_0040, 1'b0, 32'h0, 4'h0);
        bus.a_ready = 1'b1;
        step();
        bus.req_valid = 1'b0;
        check("rd_a_valid", 32'(bus.a_valid), 32'd1);
        check("rd_b_valid", 32'(bus.b_valid), 32'd0);
        check("rd_dn_addr", bus.dn_addr, 32'h0000_0040);
        check("rd_req_ready", 32'(bus.req_ready), 32'd0);
        step();
        bus.a_ready = 1'b0;
        check("rd_a_valid_drop", 32'(bus.a_valid), 32'd0);
        step();
        bus.a_resp_valid = 1'b1;
        bus.a_rdata = 32'h1234_5678;
        push_exp(32'h1234_5678, 1'b0);
        step();
        bus.a_resp_valid = 1'b0;
        check_resp("rd");
        step();
        check("rd_pulse_end", 32'(bus.resp_valid), 32'd0);
        check("rd_req_ready_back", 32'(bus.req_ready), 32'd1);
        check("rd_a_cycles", 32'(a_cyc - a0), 32'd1);
        check("rd_b_cycles", 32'(b_cyc - b0), 32'd0);

        // Write to B with ready delayed three cycles
        a0 = a_cyc; b0 = b_cyc;
        drive_req(32'h1000_0004, 1'b1, 32'hCAFE_F00D, 4'hF);
        step();
        drive_req(32'h0000_0999, 1'b0, 32'h0, 4'h0);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wr_b_valid", 32'(bus.b_valid), 32'd1);
            check("wr_dn_addr", bus.dn_addr, 32'h1000_0004);
            check("wr_dn_wdata", bus.dn_wdata, 32'hCAFE_F00D);
            step();
        end
        bus.b_ready = 1'b1;
        step();
        bus.b_ready = 1'b0;
        check("wr_b_valid_drop", 32'(bus.b_valid), 32'd0);
        bus.b_resp_valid = 1'b1;
        bus.b_rdata = 32'h0BAD_F00D;
        push_exp(32'h0BAD_F00D, 1'b0);
        step();
        bus.b_resp_valid = 1'b0;
        check_resp("wr");
        check("wr_dn_we", 32'(bus.dn_we), 32'd1);
        check("wr_dn_wstrb", 32'(bus.dn_wstrb), 32'hF);
        step();
        check("wr_b_cycles", 32'(b_cyc - b0), 32'd4);
        check("wr_a_cycles", 32'(a_cyc - a0), 32'd0);

        // Ready and response in the same ISSUE cycle, request held high
        drive_req(32'h0000_0200, 1'b0, 32'h0, 4'h0);
        bus.a_ready = 1'b1;
        bus.a_resp_valid = 1'b1;
        bus.a_rdata = 32'h1111_1111;
        push_exp(32'h1111_1111, 1'b0);
        step();
        check("b2b_req_ready_busy", 32'(bus.req_ready), 32'd0);
        step();
        check_resp("b2b_first");
        bus.a_rdata = 32'h2222_2222;
        push_exp(32'h2222_2222, 1'b0);
        step();
        check("b2b_req_ready_idle", 32'(bus.req_ready), 32'd1);
        check("b2b_pulse_end", 32'(bus.resp_valid), 32'd0);
        step();
        bus.req_valid = 1'b0;
        check("b2b_reaccept", 32'(bus.req_ready), 32'd0);
        check("b2b_a_valid", 32'(bus.a_valid), 32'd1);
        step();
        bus.a_ready = 1'b0;
        bus.a_resp_valid = 1'b0;
        check_resp("b2b_second");
        step();

        // B never ready: timeout
        drive_req(32'h1000_0100, 1'b0, 32'h0, 4'h0);
        push_exp(32'hDEAD_BEEF, 1'b1);
        step();
        bus.req_valid = 1'b0;
        hi = bus.b_valid ? 1 : 0;
        for (int i = 0; i < 40 && bus.b_valid; i++) begin
            step();
            if (bus.b_valid) hi++;
        end
        check("tmo_b_valid_cycles", 32'(hi), 32'd16);
        check_resp("tmo");
        step();
        check("tmo_pulse_end", 32'(bus.resp_valid), 32'd0);
        check("tmo_err_held", 32'(bus.resp_err), 32'd1);
        check("tmo_rdata_held", bus.resp_rdata, 32'hDEAD_BEEF);

        // Stray responses
        r0 = resp_cnt;
        bus.b_resp_valid = 1'b1;
        step();
        bus.b_resp_valid = 1'b0;
        check("stray_idle_ready", 32'(bus.req_ready), 32'd1);
        check("stray_idle_resp", 32'(bus.resp_valid), 32'd0);
        drive_req(32'h1000_0008, 1'b0, 32'h0, 4'h0);
        bus.b_ready = 1'b1;
        step();
        bus.req_valid = 1'b0;
        step();
        bus.b_ready = 1'b0;
        bus.a_resp_valid = 1'b1;
        bus.a_rdata = 32'h0000_0099;
        step();
        bus.a_resp_valid = 1'b0;
        check("stray_a_resp", 32'(bus.resp_valid), 32'd0);
        check("stray_a_busy", 32'(bus.req_ready), 32'd0);
        bus.b_resp_valid = 1'b1;
        bus.b_rdata = 32'h7777_7777;
        push_exp(32'h7777_7777, 1'b0);
        step();
        bus.b_resp_valid = 1'b0;
        check_resp("stray_b");
        step();
        check("stray_resp_count", 32'(resp_cnt - r0), 32'd1);

        // Reset during WAIT aborts without a response
        r0 = resp_cnt;
        drive_req(32'h0000_0080, 1'b0, 32'h0, 4'h0);
        bus.a_ready = 1'b1;
        step();
        bus.req_valid = 1'b0;
        step();
        bus.a_ready = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        check("abort_a_valid", 32'(bus.a_valid), 32'd0);
        check("abort_b_valid", 32'(bus.b_valid), 32'd0);
        check("abort_dn_addr", bus.dn_addr, 32'd0);
        check("abort_resp_rdata", bus.resp_rdata, 32'd0);
        bus.a_resp_valid = 1'b1;
        bus.a_rdata = 32'h5555_5555;
        step();
        bus.a_resp_valid = 1'b0;
        check("abort_late_resp", 32'(bus.resp_valid), 32'd0);
        step(); step();
        check("abort_resp_count", 32'(resp_cnt - r0), 32'd0);
        check("total_resp_pulses", 32'(resp_cnt), 32'd6);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
